// File: rtl/brams_portb_sequencer.sv
// brams_portb_sequencer: initiator for the BRAM port-B router.
// Accepts one vector command c[i] = f(a[i], b[i]), i = 0..len-1. It issues one
// read per source bank each cycle. Each write-back is delayed by
// RD_LAT+MATH_LAT cycles so that it lines up with the math pipeline result.
// Optional feature macro: BRAMS_SEQ_ABORT_EN adds an `abort` input.
// Handshake: a command is taken on a rising edge where cmd_valid & cmd_ready.
// cmd_ready is high only in IDLE. Command fields are sampled on that edge only.
// All outputs come straight from flops. Decoded outputs (adr_sel, flags) are
// computed from next-state values and then registered.
module brams_portb_sequencer #(
  parameter int BRAM_AW  = 10,
  parameter int BRAMS    = 8,
  parameter int RD_LAT   = 2,
  parameter int MATH_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef BRAMS_SEQ_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [$clog2(BRAMS)-1:0] cmd_src_a,
  input  logic [$clog2(BRAMS)-1:0] cmd_src_b,
  input  logic [$clog2(BRAMS)-1:0] cmd_dst,
  input  logic [BRAM_AW-1:0]       cmd_base_a,
  input  logic [BRAM_AW-1:0]       cmd_base_b,
  input  logic [BRAM_AW-1:0]       cmd_base_c,
  input  logic [BRAM_AW:0]         cmd_len,
  output logic [BRAM_AW-1:0]       math_adr_a,
  output logic [BRAM_AW-1:0]       math_adr_b,
  output logic [BRAM_AW-1:0]       math_adr_c,
  output logic [BRAMS*2-1:0]       adr_sel,
  output logic [$clog2(BRAMS)-1:0] dat_a_sel,
  output logic [$clog2(BRAMS)-1:0] dat_b_sel,
  output logic                     math_we,
  output logic [$clog2(BRAMS)-1:0] we_sel,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               dbg_state
);

  localparam int BW     = $clog2(BRAMS);
  localparam int LW     = BRAM_AW + 1;
  localparam int WR_DLY = RD_LAT + MATH_LAT;
  localparam logic [BRAM_AW-1:0] ONE_A = 1;
  localparam logic [LW-1:0]      ONE_L = 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t             state, state_nxt;
  logic [LW-1:0]      rd_idx, rd_idx_nxt;
  logic [LW-1:0]      len_q, len_nxt;
  logic [BRAM_AW-1:0] adr_a_nxt, adr_b_nxt, adr_c_nxt;
  logic [BW-1:0]      src_a_nxt, src_b_nxt, dst_nxt;
  // Bit j is the read-issue flag from j+1 cycles ago; the top bit is math_we.
  logic [WR_DLY-1:0]  wr_sr, wr_sr_nxt;
  logic               err_nxt;
  logic [BRAMS*2-1:0] adr_sel_nxt;
  logic               reject;

  assign reject = (cmd_src_a == cmd_src_b) || (cmd_dst == cmd_src_a) ||
                  (cmd_dst == cmd_src_b) || (cmd_len == '0);

  assign math_we   = wr_sr[WR_DLY-1];
  assign dbg_state = state;

  // State register plus every datapath and output flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_idx     <= '0;
      len_q      <= '0;
      math_adr_a <= '0;
      math_adr_b <= '0;
      math_adr_c <= '0;
      dat_a_sel  <= '0;
      dat_b_sel  <= '0;
      we_sel     <= '0;
      wr_sr      <= '0;
      adr_sel    <= '1;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_idx     <= rd_idx_nxt;
      len_q      <= len_nxt;
      math_adr_a <= adr_a_nxt;
      math_adr_b <= adr_b_nxt;
      math_adr_c <= adr_c_nxt;
      dat_a_sel  <= src_a_nxt;
      dat_b_sel  <= src_b_nxt;
      we_sel     <= dst_nxt;
      wr_sr      <= wr_sr_nxt;
      adr_sel    <= adr_sel_nxt;
      cmd_ready  <= (state_nxt == S_IDLE);
      busy       <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done       <= (state_nxt == S_DONE);
      err        <= err_nxt;
    end
  end

  // Next-state logic: command capture, read stepping, write-pointer advance.
  always_comb begin
    state_nxt  = state;
    rd_idx_nxt = rd_idx;
    len_nxt    = len_q;
    adr_a_nxt  = math_adr_a;
    adr_b_nxt  = math_adr_b;
    adr_c_nxt  = math_adr_c;
    src_a_nxt  = dat_a_sel;
    src_b_nxt  = dat_b_sel;
    dst_nxt    = we_sel;
    err_nxt    = 1'b0;
    wr_sr_nxt  = {wr_sr[WR_DLY-2:0], (state == S_RUN)};
    if (math_we) adr_c_nxt = math_adr_c + ONE_A;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          len_nxt    = cmd_len;
          src_a_nxt  = cmd_src_a;
          src_b_nxt  = cmd_src_b;
          dst_nxt    = cmd_dst;
          adr_a_nxt  = cmd_base_a;
          adr_b_nxt  = cmd_base_b;
          adr_c_nxt  = cmd_base_c;
          rd_idx_nxt = '0;
          if (reject) begin
            state_nxt = S_DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (rd_idx == len_q - ONE_L) begin
          state_nxt = S_DRAIN;
        end else begin
          rd_idx_nxt = rd_idx + ONE_L;
          adr_a_nxt  = math_adr_a + ONE_A;
          adr_b_nxt  = math_adr_b + ONE_A;
        end
      end
      S_DRAIN: begin
        if (wr_sr_nxt == '0) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef BRAMS_SEQ_ABORT_EN
    if (abort && ((state == S_RUN) || (state == S_DRAIN))) begin
      state_nxt = S_DONE;
      err_nxt   = 1'b1;
      wr_sr_nxt = '0;
    end
`endif
  end

  // Output decode: per-bank address select for the coming cycle.
  always_comb begin
    adr_sel_nxt = '1;
    if (state_nxt == S_RUN) begin
      adr_sel_nxt[{src_a_nxt, 1'b0} +: 2] = 2'b00;
      adr_sel_nxt[{src_b_nxt, 1'b0} +: 2] = 2'b01;
    end
    if (wr_sr_nxt[WR_DLY-1]) adr_sel_nxt[{dst_nxt, 1'b0} +: 2] = 2'b10;
  end

endmodule

// File: tb/tb_brams_portb_sequencer.sv
// Directed bench for brams_portb_sequencer (default parameters: WR_DLY = 5).
// Cycle t counts sample points after the accepting edge (t=1 is the first).
module tb_brams_portb_sequencer;

  logic        clk, rst_n, cmd_valid, cmd_ready;
  logic [2:0]  cmd_src_a, cmd_src_b, cmd_dst;
  logic [9:0]  cmd_base_a, cmd_base_b, cmd_base_c;
  logic [10:0] cmd_len;
  logic [9:0]  math_adr_a, math_adr_b, math_adr_c;
  logic [15:0] adr_sel;
  logic [2:0]  dat_a_sel, dat_b_sel, we_sel;
  logic        math_we, busy, done, err;
  logic [1:0]  dbg_state;
`ifdef BRAMS_SEQ_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  brams_portb_sequencer dut (
    .clk(clk), .rst_n(rst_n),
`ifdef BRAMS_SEQ_ABORT_EN
    .abort(abort),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b), .cmd_base_c(cmd_base_c),
    .cmd_len(cmd_len),
    .math_adr_a(math_adr_a), .math_adr_b(math_adr_b), .math_adr_c(math_adr_c),
    .adr_sel(adr_sel), .dat_a_sel(dat_a_sel), .dat_b_sel(dat_b_sel),
    .math_we(math_we), .we_sel(we_sel), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_sel(input bit rd, input bit wr,
                                          input logic [2:0] sa, input logic [2:0] sb,
                                          input logic [2:0] d);
    logic [15:0] s;
    s = 16'hFFFF;
    if (rd) begin
      s[2*sa +: 2] = 2'b00;
      s[2*sb +: 2] = 2'b01;
    end
    if (wr) s[2*d +: 2] = 2'b10;
    return s;
  endfunction

  task automatic drive_cmd(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] d,
                           input logic [9:0] ba, input logic [9:0] bb, input logic [9:0] bc,
                           input logic [10:0] len);
    cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d;
    cmd_base_a = ba; cmd_base_b = bb; cmd_base_c = bc;
    cmd_len = len; cmd_valid = 1'b1;
  endtask

  // Runs one legal command to completion, checking every cycle.
  task automatic run_cmd(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] d,
                         input logic [9:0] ba, input logic [9:0] bb, input logic [9:0] bc,
                         input int len, input bit hold_valid, output int done_t);
    logic [9:0] ea, eb, ec;
    bit rd, wr;
    ea = ba; eb = bb; ec = bc;
    for (int k = 0; k < len; k++) begin
      exp_q.push_back(ec);
      ec = ec + 10'd1;
    end
    done_t = -1;
    drive_cmd(sa, sb, d, ba, bb, bc, len[10:0]);
    step();
    if (!hold_valid) cmd_valid = 1'b0;
    for (int t = 1; t <= len + 6; t++) begin
      rd = (t <= len);
      wr = (t >= 6) && (t <= len + 5);
      chk("adr_sel", {16'h0, adr_sel}, {16'h0, exp_sel(rd, wr, sa, sb, d)});
      if (rd) begin
        chk("math_adr_a", {22'h0, math_adr_a}, {22'h0, ea});
        chk("math_adr_b", {22'h0, math_adr_b}, {22'h0, eb});
        ea = ea + 10'd1;
        eb = eb + 10'd1;
      end
      chk("math_we", {31'h0, math_we}, {31'h0, wr});
      if (wr && math_we && exp_q.size() > 0) begin
        chk("math_adr_c", {22'h0, math_adr_c}, {22'h0, exp_q.pop_front()});
        chk("we_sel", {29'h0, we_sel}, {29'h0, d});
      end
      chk("dat_a_sel", {29'h0, dat_a_sel}, {29'h0, sa});
      chk("dat_b_sel", {29'h0, dat_b_sel}, {29'h0, sb});
      chk("busy", {31'h0, busy}, {31'h0, (t < len + 6)});
      chk("cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("err", {31'h0, err}, 32'h0);
      if (done) done_t = t;
      step();
    end
    chk("write_count", exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  task automatic run_reject(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] d,
                            input logic [10:0] len);
    bit saw_we;
    drive_cmd(sa, sb, d, 10'h0, 10'h0, 10'h0, len);
    step();
    cmd_valid = 1'b0;
    chk("rej_done", {31'h0, done}, 32'h1);
    chk("rej_err", {31'h0, err}, 32'h1);
    chk("rej_busy", {31'h0, busy}, 32'h0);
    chk("rej_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rej_adr_sel", {16'h0, adr_sel}, 32'hFFFF);
    saw_we = math_we;
    step();
    chk("rej_ready_after", {31'h0, cmd_ready}, 32'h1);
    chk("rej_done_after", {31'h0, done}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      saw_we |= math_we;
      step();
    end
    chk("rej_no_we", {31'h0, saw_we}, 32'h0);
  endtask

  int done_t;
  bit saw_we;

  // Directed sequence
  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
    cmd_base_a = '0; cmd_base_b = '0; cmd_base_c = '0; cmd_len = '0;
`ifdef BRAMS_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_we", {31'h0, math_we}, 32'h0);
    chk("rst_adr_sel", {16'h0, adr_sel}, 32'hFFFF);
    chk("rst_adr_a", {22'h0, math_adr_a}, 32'h0);
    chk("rst_we_sel", {29'h0, we_sel}, 32'h0);

    // Basic command: done on cycle 10
    run_cmd(3'd0, 3'd1, 3'd2, 10'h000, 10'h010, 10'h020, 4, 1'b0, done_t);
    chk("t1_done_cycle", done_t, 32'd10);
    chk("t1_idle_ready", {31'h0, cmd_ready}, 32'h1);

    // Address wrap on operand a
    run_cmd(3'd4, 3'd5, 3'd6, 10'h3FE, 10'h100, 10'h3FF, 4, 1'b0, done_t);
    chk("t2_done_cycle", done_t, 32'd10);

    // Rejects
    run_reject(3'd3, 3'd3, 3'd5, 11'd4);
    run_reject(3'd3, 3'd4, 3'd3, 11'd4);
    run_reject(3'd3, 3'd4, 3'd4, 11'd4);
    run_reject(3'd3, 3'd4, 3'd5, 11'd0);

    // Back-to-back with cmd_valid held
    run_cmd(3'd7, 3'd0, 3'd1, 10'h050, 10'h060, 10'h070, 2, 1'b1, done_t);
    chk("t4_done_cycle", done_t, 32'd8);
    chk("t4_ready", {31'h0, cmd_ready}, 32'h1);
    chk("t4_we_gap", {31'h0, math_we}, 32'h0);
    step();
    cmd_valid = 1'b0;
    chk("t4_second_busy", {31'h0, busy}, 32'h1);
    chk("t4_second_adr_a", {22'h0, math_adr_a}, 32'h050);
    chk("t4_second_we", {31'h0, math_we}, 32'h0);
    for (int i = 0; i < 10; i++) step();
    chk("t4_second_end_ready", {31'h0, cmd_ready}, 32'h1);

    // Reset mid-run at k=2
    drive_cmd(3'd0, 3'd1, 3'd2, 10'h000, 10'h010, 10'h020, 11'd8);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("t5_pre_adr_a", {22'h0, math_adr_a}, 32'h002);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", {31'h0, cmd_ready}, 32'h1);
    chk("t5_rst_busy", {31'h0, busy}, 32'h0);
    chk("t5_rst_adr_sel", {16'h0, adr_sel}, 32'hFFFF);
    chk("t5_rst_adr_a", {22'h0, math_adr_a}, 32'h0);
    chk("t5_rst_dat_a_sel", {29'h0, dat_a_sel}, 32'h0);
    step();
    #2 rst_n = 1'b1;
    saw_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      saw_we |= math_we;
    end
    chk("t5_no_we", {31'h0, saw_we}, 32'h0);
    chk("t5_ready", {31'h0, cmd_ready}, 32'h1);

`ifdef BRAMS_SEQ_ABORT_EN
    // Abort at k=1
    drive_cmd(3'd0, 3'd1, 3'd2, 10'h000, 10'h010, 10'h020, 11'd8);
    step();
    cmd_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t6_done", {31'h0, done}, 32'h1);
    chk("t6_err", {31'h0, err}, 32'h1);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_adr_sel", {16'h0, adr_sel}, 32'hFFFF);
    saw_we = math_we;
    for (int i = 0; i < 10; i++) begin
      step();
      saw_we |= math_we;
    end
    chk("t6_no_we", {31'h0, saw_we}, 32'h0);
    chk("t6_ready", {31'h0, cmd_ready}, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
